// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Owns the register file's single write port. The writeback stage (WB) always
// wins; results from the long-latency unit (LU) wait in a small FIFO and are
// written in any cycle WB is idle. A pending-destination scoreboard lets decode
// stall on registers whose LU result is still outstanding. A starvation counter
// raises stall_req so the pipeline can open a slot for the FIFO head.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   wb_valid/addr/data        WB write request (cannot be back-pressured)
//   lu_valid/addr/data        LU result offer; lu_ready = FIFO not full
//   issue_valid/issue_addr    LU op issued, mark destination pending
//   chk_addr_1/2, busy_1/2    scoreboard queries (combinational)
//   stall_req                 registered request to suppress WB next cycle
//   RegWrite/Write_addr/Write_data  registered register-file write port
module regfile_wb_arbiter #(
   parameter int bit_size     = 32,
   parameter int fifo_depth   = 2,
   parameter int starve_limit = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_valid,
   input  logic [4:0]          wb_addr,
   input  logic [bit_size-1:0] wb_data,
   input  logic                lu_valid,
   output logic                lu_ready,
   input  logic [4:0]          lu_addr,
   input  logic [bit_size-1:0] lu_data,
   input  logic                issue_valid,
   input  logic [4:0]          issue_addr,
   input  logic [4:0]          chk_addr_1,
   input  logic [4:0]          chk_addr_2,
   output logic                busy_1,
   output logic                busy_2,
   output logic                stall_req,
   output logic                RegWrite,
   output logic [4:0]          Write_addr,
   output logic [bit_size-1:0] Write_data
);

   localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int CW = $clog2(fifo_depth + 1);
   localparam int SW = $clog2(starve_limit + 1);

   logic [4:0]          fifo_addr_q [fifo_depth];
   logic [bit_size-1:0] fifo_data_q [fifo_depth];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;

   logic [31:0]         pending_q, pending_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic                stall_q, stall_d;

   logic                reg_write_q, reg_write_d;
   logic [4:0]          waddr_q, waddr_d;
   logic [bit_size-1:0] wdata_q, wdata_d;

   logic                fifo_full, fifo_empty, push, pop;
   logic [4:0]          head_addr;
   logic [bit_size-1:0] head_data;

   assign fifo_full  = (count_q == CW'(fifo_depth));
   assign fifo_empty = (count_q == '0);
   assign lu_ready   = !fifo_full;
   assign push       = lu_valid && !fifo_full;
   assign pop        = !wb_valid && !fifo_empty;
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_data  = fifo_data_q[rd_ptr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_comb begin
      reg_write_d = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      if (wb_valid) begin
         reg_write_d = (wb_addr != 5'd0);
         waddr_d     = wb_addr;
         wdata_d     = wb_data;
      end else if (!fifo_empty) begin
         reg_write_d = (head_addr != 5'd0);
         waddr_d     = head_addr;
         wdata_d     = head_data;
      end
   end

   // Set after clear so a same-cycle issue to the popped address stays pending.
   always_comb begin
      pending_d = pending_q;
      if (pop) pending_d[head_addr] = 1'b0;
      if (issue_valid && issue_addr != 5'd0) pending_d[issue_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // A non-empty FIFO that does not pop can only mean WB took the port.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q < SW'(starve_limit)) begin
         starve_d = starve_q + SW'(1);
      end
      stall_d = (starve_d >= SW'(starve_limit));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pending_q   <= '0;
         starve_q    <= '0;
         stall_q     <= 1'b0;
         reg_write_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pending_q   <= pending_d;
         starve_q    <= starve_d;
         stall_q     <= stall_d;
         reg_write_q <= reg_write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Storage needs no reset: the occupancy count decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= lu_addr;
         fifo_data_q[wr_ptr_q] <= lu_data;
      end
   end

   assign busy_1     = pending_q[chk_addr_1];
   assign busy_2     = pending_q[chk_addr_2];
   assign stall_req  = stall_q;
   assign RegWrite   = reg_write_q;
   assign Write_addr = waddr_q;
   assign Write_data = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int BS = 32;
   localparam int FD = 2;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid, lu_valid, issue_valid;
   logic [4:0]    wb_addr, lu_addr, issue_addr, chk_addr_1, chk_addr_2;
   logic [BS-1:0] wb_data, lu_data;
   logic          lu_ready, busy_1, busy_2, stall_req, RegWrite;
   logic [4:0]    Write_addr;
   logic [BS-1:0] Write_data;

   regfile_wb_arbiter #(.bit_size(BS), .fifo_depth(FD), .starve_limit(SL)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
      .busy_1(busy_1), .busy_2(busy_2), .stall_req(stall_req),
      .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: FIFO as a queue, pending set as a bit array.
   typedef struct {
      logic [4:0]    a;
      logic [BS-1:0] d;
   } ent_t;

   ent_t          m_q[$];
   bit   [31:0]   m_pend;
   int            m_starve;
   bit            m_stall;
   bit            m_rw;
   logic [4:0]    m_wa;
   logic [BS-1:0] m_wd;

   task automatic model_reset();
      m_q.delete();
      m_pend   = '0;
      m_starve = 0;
      m_stall  = 1'b0;
      m_rw     = 1'b0;
      m_wa     = '0;
      m_wd     = '0;
   endtask

   task automatic drive_idle();
      wb_valid    = 1'b0; wb_addr    = '0; wb_data = '0;
      lu_valid    = 1'b0; lu_addr    = '0; lu_data = '0;
      issue_valid = 1'b0; issue_addr = '0;
      chk_addr_1  = '0;   chk_addr_2 = '0;
   endtask

   // Advance the model by one clock using the currently driven inputs, then
   // advance the DUT and return 1 time unit after the edge.
   task automatic step();
      ent_t h;
      bit   had, do_push;
      had     = (m_q.size() > 0);
      do_push = lu_valid && (m_q.size() < FD);
      if (wb_valid) begin
         m_rw = (wb_addr != 0); m_wa = wb_addr; m_wd = wb_data;
      end else if (had) begin
         h = m_q.pop_front();
         m_rw = (h.a != 0); m_wa = h.a; m_wd = h.d;
         m_pend[h.a] = 1'b0;
      end else begin
         m_rw = 1'b0;
      end
      if (had && wb_valid) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else                 m_starve = 0;
      m_stall = (m_starve >= SL);
      if (do_push) m_q.push_back('{a: lu_addr, d: lu_data});
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_valid = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
         lu_valid = 1'($urandom); lu_addr = 5'($urandom); lu_data = $urandom;
         issue_valid = 1'($urandom); issue_addr = 5'($urandom);
         chk_addr_1 = 5'($urandom); chk_addr_2 = 5'($urandom);
         @(posedge clk); #1;
         n_checks++;
         if (RegWrite !== 1'b0 || Write_addr !== 5'd0 || Write_data !== '0) begin
            n_errors++;
            $display("FAIL reset_write: RegWrite=%b addr=%0d data=%h, want 0/0/0", RegWrite, Write_addr, Write_data);
         end
         n_checks++;
         if (lu_ready !== 1'b1 || stall_req !== 1'b0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: lu_ready=%b stall=%b busy=%b%b, want 1 0 00", lu_ready, stall_req, busy_1, busy_2);
         end
      end
      model_reset();
      drive_idle();
      rst = 1'b1;
      step();
   endtask

   task automatic test_wb_only();
      drive_idle();
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      step();
      n_checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd5 || Write_data !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL wb_write: got %b/%0d/%h, want 1/5/deadbeef", RegWrite, Write_addr, Write_data);
      end
      wb_addr = 5'd0; wb_data = 32'h0000_0055;
      step();
      n_checks++;
      if (RegWrite !== 1'b0 || Write_addr !== 5'd0) begin
         n_errors++;
         $display("FAIL wb_addr0: got RegWrite=%b addr=%0d, want 0/0", RegWrite, Write_addr);
      end
      drive_idle();
      step();
      n_checks++;
      if (RegWrite !== 1'b0 || Write_data !== 32'h0000_0055) begin
         n_errors++;
         $display("FAIL idle_hold: got RegWrite=%b data=%h, want 0/00000055", RegWrite, Write_data);
      end
   endtask

   task automatic test_lu_scoreboard();
      drive_idle();
      chk_addr_1 = 5'd9;
      issue_valid = 1'b1; issue_addr = 5'd9;
      step();
      issue_valid = 1'b0;
      n_checks++;
      if (busy_1 !== 1'b1) begin
         n_errors++;
         $display("FAIL sb_set: busy_1=%b want 1", busy_1);
      end
      lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h1234;
      step();
      lu_valid = 1'b0;
      n_checks++;
      if (RegWrite !== 1'b0 || busy_1 !== 1'b1) begin
         n_errors++;
         $display("FAIL lu_latency1: RegWrite=%b busy_1=%b, want 0/1", RegWrite, busy_1);
      end
      step();
      n_checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd9 || Write_data !== 32'h1234 || busy_1 !== 1'b0) begin
         n_errors++;
         $display("FAIL lu_write: got %b/%0d/%h busy_1=%b, want 1/9/00001234 busy 0", RegWrite, Write_addr, Write_data, busy_1);
      end
   endtask

   task automatic test_contention();
      drive_idle();
      wb_valid = 1'b1; wb_addr = 5'd10; wb_data = $urandom;
      lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h3333;
      step();
      lu_addr = 5'd4; lu_data = 32'h4444; wb_data = $urandom;
      step();
      n_checks++;
      if (lu_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fifo_full: lu_ready=%b want 0", lu_ready);
      end
      // Offer another result that must be refused while full.
      lu_addr = 5'd5; lu_data = 32'h5555;
      for (int lost = 2; lost <= 5; lost++) begin
         n_checks++;
         if (stall_req !== (lost - 1 >= SL) || stall_req !== m_stall) begin
            n_errors++;
            $display("FAIL starve_%0d: stall_req=%b want %b", lost - 1, stall_req, m_stall);
         end
         wb_data = $urandom;
         step();
      end
      n_checks++;
      if (stall_req !== 1'b1 || RegWrite !== 1'b1 || Write_addr !== 5'd10) begin
         n_errors++;
         $display("FAIL stall_wb_wins: stall=%b RegWrite=%b addr=%0d, want 1/1/10", stall_req, RegWrite, Write_addr);
      end
      drive_idle();
      step();
      n_checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd3 || Write_data !== 32'h3333 || stall_req !== 1'b0) begin
         n_errors++;
         $display("FAIL drain_first: got %b/%0d/%h stall=%b, want 1/3/00003333 stall 0", RegWrite, Write_addr, Write_data, stall_req);
      end
      step();
      n_checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd4 || Write_data !== 32'h4444) begin
         n_errors++;
         $display("FAIL drain_second: got %b/%0d/%h, want 1/4/00004444", RegWrite, Write_addr, Write_data);
      end
      step();
      n_checks++;
      if (RegWrite !== 1'b0 || lu_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL drain_empty: RegWrite=%b lu_ready=%b, want 0/1", RegWrite, lu_ready);
      end
   endtask

   task automatic test_simultaneous();
      drive_idle();
      chk_addr_2 = 5'd7;
      issue_valid = 1'b1; issue_addr = 5'd7;
      step();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = $urandom;
      step();
      lu_valid = 1'b0;
      issue_valid = 1'b1; issue_addr = 5'd7;
      step();
      issue_valid = 1'b0;
      n_checks++;
      if (RegWrite !== 1'b1 || Write_addr !== 5'd7 || busy_2 !== 1'b1) begin
         n_errors++;
         $display("FAIL set_wins: RegWrite=%b addr=%0d busy_2=%b, want 1/7/1", RegWrite, Write_addr, busy_2);
      end
      step();
      n_checks++;
      if (busy_2 !== 1'b1 || RegWrite !== 1'b0) begin
         n_errors++;
         $display("FAIL set_persists: busy_2=%b RegWrite=%b, want 1/0", busy_2, RegWrite);
      end
   endtask

   task automatic test_async_reset();
      drive_idle();
      chk_addr_1 = 5'd12; chk_addr_2 = 5'd13;
      wb_valid = 1'b1; wb_addr = 5'd20; wb_data = $urandom;
      lu_valid = 1'b1; lu_addr = 5'd12; lu_data = $urandom;
      issue_valid = 1'b1; issue_addr = 5'd12;
      step();
      lu_addr = 5'd13; lu_data = $urandom; issue_addr = 5'd13;
      step();
      lu_valid = 1'b0; issue_valid = 1'b0;
      n_checks++;
      if (lu_ready !== 1'b0 || busy_1 !== 1'b1 || busy_2 !== 1'b1 || RegWrite !== 1'b1) begin
         n_errors++;
         $display("FAIL prereset_state: lu_ready=%b busy=%b%b RegWrite=%b, want 0 11 1", lu_ready, busy_1, busy_2, RegWrite);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (RegWrite !== 1'b0 || Write_addr !== 5'd0 || Write_data !== '0 || stall_req !== 1'b0 ||
          lu_ready !== 1'b1 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: RegWrite=%b addr=%0d data=%h stall=%b lu_ready=%b busy=%b%b, want all clear",
                  RegWrite, Write_addr, Write_data, stall_req, lu_ready, busy_1, busy_2);
      end
      drive_idle();
      chk_addr_1 = 5'd12; chk_addr_2 = 5'd13;
      #1 rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (RegWrite !== 1'b0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_%0d: RegWrite=%b busy=%b%b, want 0 00", i, RegWrite, busy_1, busy_2);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wb_valid    = ($urandom_range(0, 99) < 55);
         wb_addr     = 5'($urandom_range(0, 31));
         wb_data     = $urandom;
         lu_valid    = ($urandom_range(0, 99) < 50);
         lu_addr     = 5'($urandom_range(0, 7));
         lu_data     = $urandom;
         issue_valid = ($urandom_range(0, 99) < 35);
         issue_addr  = 5'($urandom_range(0, 7));
         chk_addr_1  = 5'($urandom_range(0, 7));
         chk_addr_2  = 5'($urandom_range(0, 7));
         step();
         n_checks++;
         if (RegWrite !== m_rw || (m_rw && (Write_addr !== m_wa || Write_data !== m_wd))) begin
            n_errors++;
            $display("FAIL rand_write[%0d]: got %b/%0d/%h, want %b/%0d/%h", i, RegWrite, Write_addr, Write_data, m_rw, m_wa, m_wd);
         end
         n_checks++;
         if (Write_addr !== m_wa || Write_data !== m_wd) begin
            n_errors++;
            $display("FAIL rand_hold[%0d]: got %0d/%h, want %0d/%h", i, Write_addr, Write_data, m_wa, m_wd);
         end
         n_checks++;
         if (stall_req !== m_stall || lu_ready !== (m_q.size() < FD)) begin
            n_errors++;
            $display("FAIL rand_status[%0d]: stall=%b lu_ready=%b, want %b/%b", i, stall_req, lu_ready, m_stall, m_q.size() < FD);
         end
         n_checks++;
         if (busy_1 !== m_pend[chk_addr_1] || busy_2 !== m_pend[chk_addr_2]) begin
            n_errors++;
            $display("FAIL rand_busy[%0d]: busy=%b%b, want %b%b", i, busy_1, busy_2, m_pend[chk_addr_1], m_pend[chk_addr_2]);
         end
      end
   endtask

   initial begin
      drive_idle();
      model_reset();
      rst = 1'b0;
      test_reset();
      test_wb_only();
      test_lu_scoreboard();
      test_contention();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
